i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 151 +++++++++++++++
 tb/tb_i2s_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
// Mono I2S transmitter. Generates its own bit clock from the system clock and
// serializes one signed sample per 64-bit frame, duplicated into the left and
// right slots with standard I2S timing (MSB one sclk after the lrclk edge).
// Samples arrive on a one-cycle strobe into a single-entry holding register;
// the frame register is refreshed from it at each frame boundary.
//
// Parameters
//   DATA_WIDTH : sample width in bits (8..31)
//   CLK_DIV    : clk cycles per sclk half-period (>= 1)
//
// Ports
//   clk     in   system clock, all logic on the rising edge
//   rst_n   in   synchronous active-low reset
//   data_i  in   signed mono sample
//   vld_i   in   one-cycle strobe qualifying data_i
//   sclk    out  I2S bit clock
//   lrclk   out  I2S word select (0 = left, 1 = right)
//   sdata   out  I2S serial data, MSB first
//   urun_o  out  pulse: a frame started with no new sample pending
//   ovf_o   out  pulse: a pending sample was overwritten
// ---------------------------------------------------------------------------
module i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic                  sclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  urun_o,
  output logic                  ovf_o
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [5:0]    BIT_LAST  = 6'd63;

  logic [TW-1:0]         tickCnt_q, tickCnt_d;
  logic                  sclk_q,    sclk_d;
  logic [5:0]            bitCnt_q,  bitCnt_d;
  logic                  lrclk_q,   lrclk_d;
  logic                  sdata_q,   sdata_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [DATA_WIDTH-1:0] hold_q,    hold_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] frame_q,   frame_d;
  logic                  urun_q,    urun_d;
  logic                  ovf_q,     ovf_d;

  logic tick;
  logic fallTick;
  logic frameLoad;

  // A falling tick is the tick that drives sclk from 1 to 0; the one where the
  // bit counter wraps 63->0 is the frame boundary.
  always_comb begin
    tick      = (tickCnt_q == TICK_LAST);
    fallTick  = tick && sclk_q;
    frameLoad = fallTick && (bitCnt_q == BIT_LAST);
  end

  always_comb begin
    tickCnt_d = tick ? '0 : (tickCnt_q + TICK_ONE);
    sclk_d    = tick ? ~sclk_q : sclk_q;
    bitCnt_d  = bitCnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    frame_d   = frame_q;
    urun_d    = 1'b0;
    ovf_d     = 1'b0;

    // Outputs are registered against the new bit position so they always
    // describe the current bitCnt_q and only move on falling ticks. Slot bit 1
    // takes the MSB and primes the shifter; later bits shift out, and once the
    // sample is exhausted the shifter holds zeros for the slot tail.
    if (fallTick) begin
      bitCnt_d = bitCnt_q + 6'd1;
      lrclk_d  = bitCnt_d[5];
      if (bitCnt_d[4:0] == 5'd0) begin
        sdata_d = 1'b0;
      end else if (bitCnt_d[4:0] == 5'd1) begin
        sdata_d = frame_q[DATA_WIDTH-1];
        shift_d = frame_q << 1;
      end else begin
        sdata_d = shift_q[DATA_WIDTH-1];
        shift_d = shift_q << 1;
      end
    end

    // A strobe landing on the boundary itself bypasses the holding register,
    // which also retires any older pending sample without flagging overflow.
    if (frameLoad) begin
      pending_d = 1'b0;
      if (vld_i) begin
        frame_d = data_i;
      end else if (pending_q) begin
        frame_d = hold_q;
      end else begin
        urun_d = 1'b1;
      end
    end else if (vld_i) begin
      hold_d    = data_i;
      pending_d = 1'b1;
      ovf_d     = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tickCnt_q <= '0;
      sclk_q    <= 1'b0;
      bitCnt_q  <= '0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      shift_q   <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      urun_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      tickCnt_q <= tickCnt_d;
      sclk_q    <= sclk_d;
      bitCnt_q  <= bitCnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      urun_q    <= urun_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sclk   = sclk_q;
  assign lrclk  = lrclk_q;
  assign sdata  = sdata_q;
  assign urun_o = urun_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx
// Testbench for i2s_tx with DATA_WIDTH=24, CLK_DIV=2 (256 clk per frame).
// A reference model predicts every output on every cycle from the edge count
// since reset: sclk, lrclk and the slot bit follow from plain arithmetic on
// that count, and each frame's sample is picked from the queue of strobes
// seen in its load window. A table of per-frame scenarios adds constant
// expected words and pulse counts on top of the model.
// ---------------------------------------------------------------------------
module tb_i2s_tx;

  localparam int DW    = 24;
  localparam int DIV   = 2;
  localparam int FRAME = 128 * DIV;
  localparam int NV    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_i;
  logic          vld_i;
  logic          sclk;
  logic          lrclk;
  logic          sdata;
  logic          urun_o;
  logic          ovf_o;

  i2s_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .vld_i  (vld_i),
    .sclk   (sclk),
    .lrclk  (lrclk),
    .sdata  (sdata),
    .urun_o (urun_o),
    .ovf_o  (ovf_o)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  typedef struct {
    int          edgeNum;
    logic [DW-1:0] data;
  } strobe_t;

  typedef struct {
    int            nStrobes;
    int            off0;
    logic [DW-1:0] d0;
    int            off1;
    logic [DW-1:0] d1;
    logic [DW-1:0] expWord;
    int            expUrun;
    int            expOvf;
  } vec_t;

  strobe_t       strobeQ[$];
  vec_t          vecs[NV];
  logic [DW-1:0] frameSample;
  int            n;
  int            checks;
  int            passes;
  int            winUrun;
  int            winOvf;
  logic          prevSclk;
  logic [DW-1:0] capL, capR, doneL, doneR;

  // Comparison with a pass counter; prints one line on a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passes++;
  endtask

  // Advance one clock: update the model at the rising edge, then compare all
  // outputs and capture the serial words half a cycle later.
  task automatic tick1();
    logic          expUrun, expOvf, expSclk, expLr, expSd, hit;
    logic [DW-1:0] pick, tmp;
    int            b, k, lastLoad;
    @(posedge clk);
    expUrun = 1'b0;
    expOvf  = 1'b0;
    pick    = '0;
    if (!rst_n) begin
      n = 0;
      strobeQ.delete();
      frameSample = '0;
    end else begin
      n++;
      if (vld_i) begin
        if (n % FRAME != 0) begin
          lastLoad = ((n - 1) / FRAME) * FRAME;
          foreach (strobeQ[i]) if (strobeQ[i].edgeNum > lastLoad) expOvf = 1'b1;
        end
        strobeQ.push_back('{n, data_i});
      end
      if (n % FRAME == 0) begin
        hit = 1'b0;
        foreach (strobeQ[i]) begin
          if (strobeQ[i].edgeNum > n - FRAME) begin
            hit  = 1'b1;
            pick = strobeQ[i].data;
          end
        end
        if (hit) frameSample = pick;
        else     expUrun = 1'b1;
        strobeQ.delete();
      end
    end
    expSclk = ((n / DIV) % 2) == 1;
    b       = (n / (2 * DIV)) % 64;
    k       = b % 32;
    expLr   = (b >= 32);
    tmp     = frameSample >> (DW - k);
    expSd   = (k >= 1 && k <= DW) ? tmp[0] : 1'b0;
    @(negedge clk);
    checkOutput($sformatf("outputs{sclk,lrclk,sdata,urun,ovf} n=%0d", n),
                {27'b0, sclk, lrclk, sdata, urun_o, ovf_o},
                {27'b0, expSclk, expLr, expSd, expUrun, expOvf});
    if (urun_o) winUrun++;
    if (ovf_o)  winOvf++;
    if (n == 0) begin
      capL  = '0;
      capR  = '0;
      doneL = '1;
      doneR = '1;
    end else if (sclk && !prevSclk) begin
      if (k >= 1 && k <= DW) begin
        if (b < 32) capL = {capL[DW-2:0], sdata};
        else        capR = {capR[DW-2:0], sdata};
      end
      if (b == 63) begin
        doneL = capL;
        doneR = capR;
        capL  = '0;
        capR  = '0;
      end
    end
    prevSclk = sclk;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
    vld_i  = v;
    data_i = d;
    tick1();
    vld_i  = 1'b0;
    data_i = '0;
  endtask

  initial begin
    logic [DW-1:0] prevExp;
    int            base;
    checks   = 0;
    passes   = 0;
    n        = 0;
    winUrun  = 0;
    winOvf   = 0;
    prevSclk = 1'b0;
    capL = '0; capR = '0; doneL = '1; doneR = '1;
    frameSample = '0;
    rst_n  = 1'b0;
    vld_i  = 1'b0;
    data_i = '0;

    // nStrobes, off0, d0, off1, d1, expWord, expUrun, expOvf
    // Offsets are edges after the window start; 256 is the next frame load.
    vecs[0] = '{1, 100, 24'hA50F3C, 0,   24'h000000, 24'hA50F3C, 0, 0};
    vecs[1] = '{0, 0,   24'h000000, 0,   24'h000000, 24'hA50F3C, 1, 0};
    vecs[2] = '{2, 50,  24'h000001, 120, 24'h7FFFFF, 24'h7FFFFF, 0, 1};
    vecs[3] = '{1, 256, 24'h800000, 0,   24'h000000, 24'h800000, 0, 0};
    vecs[4] = '{2, 10,  24'h123456, 256, 24'h654321, 24'h654321, 0, 0};
    vecs[5] = '{1, 1,   24'h0FFFF0, 0,   24'h000000, 24'h0FFFF0, 0, 0};
    vecs[6] = '{0, 0,   24'h000000, 0,   24'h000000, 24'h0FFFF0, 1, 0};
    vecs[7] = '{1, 255, 24'h3C3C3C, 0,   24'h000000, 24'h3C3C3C, 0, 0};

    // Reset held for three edges, then released.
    for (int i = 0; i < 3; i++) tick1();
    rst_n = 1'b1;

    // Table: vector i strobes during window i and is seen in frame i+1,
    // while frame i (the previous vector's word) is captured.
    prevExp = '0;
    for (int i = 0; i < NV; i++) begin
      winUrun = 0;
      winOvf  = 0;
      for (int off = 1; off <= FRAME; off++) begin
        if (vecs[i].nStrobes > 0 && off == vecs[i].off0)
          applyStimulus(1'b1, vecs[i].d0);
        else if (vecs[i].nStrobes > 1 && off == vecs[i].off1)
          applyStimulus(1'b1, vecs[i].d1);
        else
          applyStimulus(1'b0, '0);
      end
      checkOutput($sformatf("vec%0d urun pulses", i), winUrun, vecs[i].expUrun);
      checkOutput($sformatf("vec%0d ovf pulses", i), winOvf, vecs[i].expOvf);
      checkOutput($sformatf("frame%0d left word", i), {8'b0, doneL}, {8'b0, prevExp});
      checkOutput($sformatf("frame%0d right word", i), {8'b0, doneR}, {8'b0, prevExp});
      prevExp = vecs[i].expWord;
    end
    for (int off = 1; off <= FRAME; off++) applyStimulus(1'b0, '0);
    checkOutput("frame8 left word", {8'b0, doneL}, {8'b0, prevExp});
    checkOutput("frame8 right word", {8'b0, doneR}, {8'b0, prevExp});

    // Mid-frame reset at bit 40 with a sample pending.
    base = n;
    winOvf = 0;
    for (int off = 1; off <= 160; off++) begin
      if (off == 20) applyStimulus(1'b1, 24'h5A5A5A);
      else           applyStimulus(1'b0, '0);
    end
    rst_n = 1'b0;
    tick1();
    rst_n = 1'b1;
    checkOutput("reset abort edge count", n, 0);
    checkOutput("reset abort ovf pulses", winOvf, 0);
    winUrun = 0;
    winOvf  = 0;
    for (int off = 1; off < FRAME; off++) applyStimulus(1'b0, '0);
    checkOutput("post-reset frame0 urun pulses", winUrun, 0);
    checkOutput("post-reset frame0 ovf pulses", winOvf, 0);
    checkOutput("post-reset frame0 left word", {8'b0, doneL}, 32'h0);
    checkOutput("post-reset frame0 right word", {8'b0, doneR}, 32'h0);
    applyStimulus(1'b0, '0);

    // Random strobes, occasionally landing on the load edge itself.
    for (int c = 0; c < 6 * FRAME; c++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 3 || (((n + 1) % FRAME == 0) && r < 100))
        applyStimulus(1'b1, DW'($urandom));
      else
        applyStimulus(1'b0, '0);
    end
    for (int c = 0; c < FRAME; c++) applyStimulus(1'b0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
